// File: rtl/ctrl_pipe_pkg.sv
// ============================================================================
// Module : ctrl_pipe_pkg
// Brief  : Shared CPU control definitions: opcodes, ALU ops, forward selects,
//          stage control flags and the bubble word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ctrl_pipe_pkg;

    localparam logic [3:0] c_OPC_RTYPE = 4'b0000;
    localparam logic [3:0] c_OPC_LW    = 4'b0011;
    localparam logic [3:0] c_OPC_SW    = 4'b1011;
    localparam logic [3:0] c_OPC_ADDI  = 4'b1001;
    localparam logic [3:0] c_OPC_ORI   = 4'b1101;

    typedef enum logic [1:0] {
        ALU_RTYPE = 2'b00,
        ALU_ADD   = 2'b01,
        ALU_SUB   = 2'b10,
        ALU_OR    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       reg_w;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_w;
    } ctrl_flags_t;

    localparam ctrl_flags_t c_CTRL_BUBBLE = '0;

    // R-type reads rt as an ALU operand; stores read rt as the store data.
    function automatic logic uses_rt(input logic reg_dst, input logic mem_w);
        return reg_dst | mem_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
// ============================================================================
// Module : ctrl_pipe_if
// Brief  : Decode-side control bus and EX/MEM/WB control outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ctrl_pipe_if #(
    parameter int REG_AW = 4
);
    logic              id_valid;
    logic [1:0]        id_alu_op;
    logic              id_reg_dst;
    logic              id_reg_w;
    logic              id_alu_src;
    logic              id_mem_to_reg;
    logic              id_mem_w;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              flush;

    logic              stall;
    logic              ex_valid;
    logic [1:0]        ex_alu_op;
    logic              ex_alu_src;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_valid;
    logic              mem_mem_w;
    logic              mem_mem_r;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_valid;
    logic              wb_reg_w;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_dst;

    modport master (
        output id_valid, id_alu_op, id_reg_dst, id_reg_w, id_alu_src,
               id_mem_to_reg, id_mem_w, id_rs, id_rt, id_rd, flush,
        input  stall, ex_valid, ex_alu_op, ex_alu_src, ex_rs, ex_rt,
               fwd_a, fwd_b, mem_valid, mem_mem_w, mem_mem_r, mem_dst,
               wb_valid, wb_reg_w, wb_mem_to_reg, wb_dst
    );

    modport slave (
        input  id_valid, id_alu_op, id_reg_dst, id_reg_w, id_alu_src,
               id_mem_to_reg, id_mem_w, id_rs, id_rt, id_rd, flush,
        output stall, ex_valid, ex_alu_op, ex_alu_src, ex_rs, ex_rt,
               fwd_a, fwd_b, mem_valid, mem_mem_w, mem_mem_r, mem_dst,
               wb_valid, wb_reg_w, wb_mem_to_reg, wb_dst
    );

endinterface

`default_nettype wire

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// ============================================================================
// Module : hazard_fwd_unit
// Brief  : Combinational load-use stall detection and EX operand forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  wire logic              i_id_valid,
    input  wire logic              i_id_uses_rt,
    input  wire logic [REG_AW-1:0] i_id_rs,
    input  wire logic [REG_AW-1:0] i_id_rt,
    input  wire logic              i_flush,
    input  wire logic              i_ex_valid,
    input  wire logic              i_ex_uses_rt,
    input  wire logic              i_ex_reg_w,
    input  wire logic              i_ex_mem_to_reg,
    input  wire logic [REG_AW-1:0] i_ex_rs,
    input  wire logic [REG_AW-1:0] i_ex_rt,
    input  wire logic [REG_AW-1:0] i_ex_dst,
    input  wire logic              i_mem_valid,
    input  wire logic              i_mem_reg_w,
    input  wire logic              i_mem_mem_r,
    input  wire logic [REG_AW-1:0] i_mem_dst,
    input  wire logic              i_wb_valid,
    input  wire logic              i_wb_reg_w,
    input  wire logic [REG_AW-1:0] i_wb_dst,
    output fwd_sel_e               o_fwd_a,
    output fwd_sel_e               o_fwd_b,
    output logic                   o_stall
);

    logic w_load_in_ex;
    logic w_id_hit;
    logic w_mem_src;
    logic w_wb_src;

    // r0 is hard-wired zero, so it can never be a real producer.
    function automatic logic real_reg(input logic [REG_AW-1:0] r);
        return (r != '0) || !R0_ZERO;
    endfunction

    // EX/MEM is the younger producer and therefore wins over MEM/WB.
    function automatic fwd_sel_e pick_src(
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_dst,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wb_dst,
        input logic [REG_AW-1:0] src
    );
        if (mem_ok && (mem_dst == src)) begin
            return FWD_MEM;
        end else if (wb_ok && (wb_dst == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        w_load_in_ex = i_ex_valid & i_ex_mem_to_reg & i_ex_reg_w & real_reg(i_ex_dst);
        w_id_hit     = (i_ex_dst == i_id_rs) | (i_id_uses_rt & (i_ex_dst == i_id_rt));
        o_stall      = i_id_valid & w_load_in_ex & w_id_hit & ~i_flush;

        // A load in MEM has no data yet; it is picked up from MEM/WB instead.
        w_mem_src = i_mem_valid & i_mem_reg_w & ~i_mem_mem_r & real_reg(i_mem_dst);
        w_wb_src  = i_wb_valid & i_wb_reg_w & real_reg(i_wb_dst);

        o_fwd_a = FWD_RF;
        o_fwd_b = FWD_RF;
        if (i_ex_valid) begin
            o_fwd_a = pick_src(w_mem_src, i_mem_dst, w_wb_src, i_wb_dst, i_ex_rs);
            if (i_ex_uses_rt) begin
                o_fwd_b = pick_src(w_mem_src, i_mem_dst, w_wb_src, i_wb_dst, i_ex_rt);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe.sv
// ============================================================================
// Module : ctrl_pipe
// Brief  : ID/EX, EX/MEM and MEM/WB control registers with hazard/forward unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    ctrl_pipe_if.slave bus
);

    ctrl_flags_t       w_id_ctrl;
    logic [REG_AW-1:0] w_id_rs;
    logic [REG_AW-1:0] w_id_rt;
    logic [REG_AW-1:0] w_id_dst;
    logic              w_stall;
    fwd_sel_e          w_fwd_a;
    fwd_sel_e          w_fwd_b;

    ctrl_flags_t       r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_dst;

    logic              r_mem_valid;
    logic              r_mem_reg_w;
    logic              r_mem_mem_w;
    logic              r_mem_mem_r;
    logic [REG_AW-1:0] r_mem_dst;

    logic              r_wb_valid;
    logic              r_wb_reg_w;
    logic              r_wb_mem_to_reg;
    logic [REG_AW-1:0] r_wb_dst;

    // Anything not accepted this cycle enters EX as an all-zero bubble.
    always_comb begin
        w_id_ctrl = c_CTRL_BUBBLE;
        w_id_rs   = '0;
        w_id_rt   = '0;
        w_id_dst  = '0;
        if (bus.id_valid && !w_stall && !bus.flush) begin
            w_id_ctrl.valid      = 1'b1;
            w_id_ctrl.alu_op     = bus.id_alu_op;
            w_id_ctrl.reg_dst    = bus.id_reg_dst;
            w_id_ctrl.reg_w      = bus.id_reg_w & ~bus.id_mem_w;
            w_id_ctrl.alu_src    = bus.id_alu_src;
            w_id_ctrl.mem_to_reg = bus.id_mem_to_reg;
            w_id_ctrl.mem_w      = bus.id_mem_w;
            w_id_rs              = bus.id_rs;
            w_id_rt              = bus.id_rt;
            w_id_dst             = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl       <= c_CTRL_BUBBLE;
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_ex_dst        <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_reg_w     <= 1'b0;
            r_mem_mem_w     <= 1'b0;
            r_mem_mem_r     <= 1'b0;
            r_mem_dst       <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_w      <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_dst        <= '0;
        end else begin
            r_ex_ctrl       <= w_id_ctrl;
            r_ex_rs         <= w_id_rs;
            r_ex_rt         <= w_id_rt;
            r_ex_dst        <= w_id_dst;
            r_mem_valid     <= r_ex_ctrl.valid;
            r_mem_reg_w     <= r_ex_ctrl.reg_w;
            r_mem_mem_w     <= r_ex_ctrl.mem_w;
            r_mem_mem_r     <= r_ex_ctrl.mem_to_reg;
            r_mem_dst       <= r_ex_dst;
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_w      <= r_mem_reg_w;
            r_wb_mem_to_reg <= r_mem_mem_r;
            r_wb_dst        <= r_mem_dst;
        end
    end

    hazard_fwd_unit #(
        .REG_AW  (REG_AW),
        .R0_ZERO (R0_ZERO)
    ) u_hazard_fwd (
        .i_id_valid      (bus.id_valid),
        .i_id_uses_rt    (uses_rt(bus.id_reg_dst, bus.id_mem_w)),
        .i_id_rs         (bus.id_rs),
        .i_id_rt         (bus.id_rt),
        .i_flush         (bus.flush),
        .i_ex_valid      (r_ex_ctrl.valid),
        .i_ex_uses_rt    (uses_rt(r_ex_ctrl.reg_dst, r_ex_ctrl.mem_w)),
        .i_ex_reg_w      (r_ex_ctrl.reg_w),
        .i_ex_mem_to_reg (r_ex_ctrl.mem_to_reg),
        .i_ex_rs         (r_ex_rs),
        .i_ex_rt         (r_ex_rt),
        .i_ex_dst        (r_ex_dst),
        .i_mem_valid     (r_mem_valid),
        .i_mem_reg_w     (r_mem_reg_w),
        .i_mem_mem_r     (r_mem_mem_r),
        .i_mem_dst       (r_mem_dst),
        .i_wb_valid      (r_wb_valid),
        .i_wb_reg_w      (r_wb_reg_w),
        .i_wb_dst        (r_wb_dst),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b),
        .o_stall         (w_stall)
    );

    assign bus.stall         = w_stall;
    assign bus.fwd_a         = w_fwd_a;
    assign bus.fwd_b         = w_fwd_b;
    assign bus.ex_valid      = r_ex_ctrl.valid;
    assign bus.ex_alu_op     = r_ex_ctrl.alu_op;
    assign bus.ex_alu_src    = r_ex_ctrl.alu_src;
    assign bus.ex_rs         = r_ex_rs;
    assign bus.ex_rt         = r_ex_rt;
    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_mem_w     = r_mem_mem_w;
    assign bus.mem_mem_r     = r_mem_mem_r;
    assign bus.mem_dst       = r_mem_dst;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_reg_w      = r_wb_reg_w;
    assign bus.wb_mem_to_reg = r_wb_mem_to_reg;
    assign bus.wb_dst        = r_wb_dst;

endmodule

`default_nettype wire
